// File: rtl/sample_pkg.sv
// rtl/sample_pkg.sv - sample type, saturation limits and echo FSM state encoding
package sample_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [7:0]                 gain_t;

    localparam sample_t SAMPLE_MAX = sample_t'({1'b0, {(SAMPLE_W-1){1'b1}}});
    localparam sample_t SAMPLE_MIN = sample_t'({1'b1, {(SAMPLE_W-1){1'b0}}});

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_RD,
        ST_CALC,
        ST_OUT
    } echo_state_e;

    // Clamp a one-bit-wider sum back into sample range; the top two bits
    // disagree exactly when the sum overflowed.
    function automatic sample_t sat_sample(input logic signed [SAMPLE_W:0] v);
        if (v[SAMPLE_W] != v[SAMPLE_W-1]) begin
            return v[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
        end
        return sample_t'(v[SAMPLE_W-1:0]);
    endfunction

endpackage

// File: rtl/echo_ram.sv
// rtl/echo_ram.sv - simple dual-port delay-line RAM, synchronous read
// Ports:
//   clk            clock
//   we_i/waddr_i/wdata_i   write port
//   raddr_i/rdata_o        read port, data valid one cycle after address
// Read of the address being written in the same cycle returns the old word.
// Contents have no reset so the array maps onto block RAM.
module echo_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_echo.sv
// rtl/axis_echo.sv - feedback echo stage on a sample stream
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   axis_in_data/vld/rdy     input sample stream (sink)
//   axis_out_data/vld/rdy    echoed sample stream (source)
//   delay_len                echo distance in samples, 0 = bypass
//   fb_gain                  unsigned Q0.8 feedback gain
//   busy                     high while the delay line is being zeroed
module axis_echo
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_W,
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] axis_in_data,
    input  logic                  axis_in_vld,
    output logic                  axis_in_rdy,
    output logic [DATA_WIDTH-1:0] axis_out_data,
    output logic                  axis_out_vld,
    input  logic                  axis_out_rdy,
    input  logic [DEPTH_LOG2-1:0] delay_len,
    input  gain_t                 fb_gain,
    output logic                  busy
);

    echo_state_e           state_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, clr_cnt_q, d_q;
    sample_t               x_q, out_data_q;
    gain_t                 g_q;
    logic                  in_rdy_q, out_vld_q, busy_q;

    sample_t                   ram_rdata;
    logic                      ram_we;
    logic [DEPTH_LOG2-1:0]     ram_waddr, ram_raddr;
    sample_t                   ram_wdata;

    logic signed [SAMPLE_W+8:0] d_ext, g_ext, prod, prod_sh;
    logic signed [SAMPLE_W:0]   sum;
    sample_t                    y;
    logic                       unused_prod_hi;

    // Feedback arithmetic; the product always fits the low 25 bits after the shift.
    always_comb begin
        d_ext   = {{9{ram_rdata[SAMPLE_W-1]}}, ram_rdata};
        g_ext   = {{SAMPLE_W{1'b0}}, 1'b0, g_q};
        prod    = d_ext * g_ext;
        prod_sh = prod >>> 8;
        sum     = {x_q[SAMPLE_W-1], x_q} + prod_sh[SAMPLE_W:0];
        y       = (d_q == '0) ? x_q : sat_sample(sum);
    end

    assign unused_prod_hi = ^prod_sh[SAMPLE_W+8:SAMPLE_W+1];

    // Writes are gated by rst so a sample caught in CALC at reset never lands.
    assign ram_we    = rst && (state_q == ST_CLEAR || state_q == ST_CALC);
    assign ram_waddr = (state_q == ST_CLEAR) ? clr_cnt_q : wr_ptr_q;
    assign ram_wdata = (state_q == ST_CLEAR) ? '0 : y;
    assign ram_raddr = wr_ptr_q - d_q;

    echo_ram #(
        .DATA_WIDTH(SAMPLE_W),
        .ADDR_WIDTH(DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            wr_ptr_q   <= '0;
            clr_cnt_q  <= '0;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        in_rdy_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (axis_in_vld && in_rdy_q) begin
                        x_q      <= sample_t'(axis_in_data);
                        d_q      <= delay_len;
                        g_q      <= fb_gain;
                        in_rdy_q <= 1'b0;
                        state_q  <= ST_RD;
                    end
                end
                ST_RD: begin
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    wr_ptr_q   <= wr_ptr_q + 1'b1;
                    out_data_q <= y;
                    out_vld_q  <= 1'b1;
                    state_q    <= ST_OUT;
                end
                ST_OUT: begin
                    if (axis_out_rdy) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign axis_in_rdy   = in_rdy_q;
    assign axis_out_vld  = out_vld_q;
    assign axis_out_data = out_data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_echo.sv
// tb/tb_axis_echo.sv - randomized self-checking bench for axis_echo
module tb_axis_echo;

    localparam int DW    = 24;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_vld = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [DL-1:0] delay_len = '0;
    logic [7:0]    fb_gain = '0;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    int mem_m [DEPTH];
    int wp_m;

    always #5 clk = ~clk;

    axis_echo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk           (clk),
        .rst           (rst),
        .axis_in_data  (in_data),
        .axis_in_vld   (in_vld),
        .axis_in_rdy   (in_rdy),
        .axis_out_data (out_data),
        .axis_out_vld  (out_vld),
        .axis_out_rdy  (out_rdy),
        .delay_len     (delay_len),
        .fb_gain       (fb_gain),
        .busy          (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Echo rule in plain integer arithmetic: floor(d*g/256), then clamp.
    task automatic model_step(input int x, input int d, input int g, output int y);
        longint p, t;
        if (d == 0) begin
            y = x;
        end else begin
            p = longint'(mem_m[(wp_m - d + DEPTH) % DEPTH]) * longint'(g);
            t = (p >= 0) ? p / 256 : -((-p + 255) / 256);
            t = longint'(x) + t;
            if (t > 8388607)  t = 8388607;
            if (t < -8388608) t = -8388608;
            y = int'(t);
        end
        mem_m[wp_m] = y;
        wp_m = (wp_m + 1) % DEPTH;
    endtask

    task automatic do_reset(input string tag);
        int cyc;
        bit rdy_low;
        rst = 1'b0; in_vld = 1'b0; out_rdy = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check({tag, "_rst_busy"}, busy, 1);
        check({tag, "_rst_vld"}, out_vld, 0);
        check({tag, "_rst_rdy"}, in_rdy, 0);
        check({tag, "_rst_data"}, out_data, 0);
        rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        wp_m = 0;
        cyc = 0;
        rdy_low = 1'b1;
        while (busy === 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (busy === 1'b1 && in_rdy !== 1'b0) rdy_low = 1'b0;
        end
        check({tag, "_clear_cycles"}, cyc, DEPTH);
        check({tag, "_clear_rdy_low"}, rdy_low, 1);
        check({tag, "_idle_rdy"}, in_rdy, 1);
    endtask

    task automatic send(input int x, input int d, input int g, input int stall,
                        input string tag, output int y_out);
        int exp_y, cyc;
        logic [DW-1:0] held;
        bit ok;
        logic [31:0] xv;
        xv = x;
        in_data = xv[DW-1:0]; in_vld = 1'b1;
        delay_len = DL'(d); fb_gain = 8'(g);
        out_rdy = (stall == 0);
        cyc = 0;
        while (in_rdy !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_accept_wait"}, (cyc < 200) ? 1 : 0, 1);
        @(posedge clk); #1;
        model_step(x, d, g, exp_y);
        // Scramble inputs to show only the accept-time values matter.
        in_vld = 1'b0; in_data = DW'($urandom);
        delay_len = DL'($urandom); fb_gain = 8'($urandom);
        cyc = 1;
        while (out_vld !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_data"}, $signed(out_data), exp_y);
        if (stall > 0) begin
            held = out_data; ok = 1'b1; in_vld = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                if (in_rdy !== 1'b0 || out_vld !== 1'b1 || out_data !== held) ok = 1'b0;
            end
            check({tag, "_stall_hold"}, ok, 1);
            in_vld = 1'b0; out_rdy = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_vld_drop"}, out_vld, 0);
        y_out = exp_y;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int y, cyc, x, d, g, st;
        logic [DW-1:0] r;

        // 1: reset and clear sweep
        do_reset("t1");

        // 2: bypass
        send(32'h000100, 0, 128, 0, "t2a", y);
        check("t2a_const", y, 32'h000100);
        send(32'h7FFFFF, 0, 128, 0, "t2b", y);
        check("t2b_const", y, 32'h7FFFFF);

        // 3: impulse with D=2, half gain
        do_reset("t3");
        for (int k = 0; k < 9; k++) begin
            send((k == 0) ? 32'h100000 : 0, 2, 128, 0, "t3", y);
            check("t3_const", y, (k % 2 == 0) ? (32'h100000 >> (k / 2)) : 0);
        end

        // 4: saturation both ways
        do_reset("t4");
        send(32'h7FFFFF, 1, 255, 0, "t4p0", y);
        send(32'h7FFFFF, 1, 255, 0, "t4p1", y);
        check("t4_pos_sat", y, 8388607);
        send(-8388608, 1, 255, 0, "t4n0", y);
        send(-8388608, 1, 255, 0, "t4n1", y);
        check("t4_neg_sat", y, -8388608);

        // 5: backpressure plus random traffic
        for (int k = 0; k < 20; k++) begin
            r = DW'($urandom);
            x = $signed(r);
            d = $urandom_range(0, DEPTH - 1);
            g = $urandom_range(0, 255);
            st = (k == 0) ? 10 : $urandom_range(0, 3);
            send(x, d, g, st, "t5", y);
        end

        // wrap: longest echo across two pointer wraps
        for (int k = 0; k < 40; k++) begin
            r = DW'($urandom);
            x = $signed(r);
            send(x, DEPTH - 1, $urandom_range(0, 255), 0, "twrap", y);
        end

        // 6: reset while a sample sits in CALC
        in_data = 24'h123456; in_vld = 1'b1; delay_len = 3; fb_gain = 255; out_rdy = 1'b1;
        cyc = 0;
        while (in_rdy !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("t6_accept_wait", (cyc < 200) ? 1 : 0, 1);
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_vld_after_rst", out_vld, 0);
        do_reset("t6");
        for (int k = 0; k < 4; k++) begin
            send(0, 3, 255, 0, "t6", y);
            check("t6_zero", $signed(out_data), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
